uart_mmio: RTL
==============

# uart_mmio

Memory-mapped 8N1 UART peripheral sitting directly downstream of the address decoder. It consumes the decoder's `CE_UART`/`CE_SR`/`UART_WR`/`UART_RD` strobes for the data register at 0x500 and the status register at 0x504. It drives the serial `TXD` line and samples `RXD`. It returns read data to the CPU's load-data mux.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 434 — clock cycles per serial bit (50 MHz / 115200). Legal range is ≥ 4.

Ports:
- `CLK` in 1 — single system clock; all logic is on the rising edge.
- `RESET_N` in 1 — reset, synchronous, active-low.
- `CE_UART` in 1 — data register (0x500) selected.
- `CE_SR` in 1 — status register (0x504) selected.
- `UART_WR` in 1 — write strobe.
- `UART_RD` in 1 — read strobe.
- `WriteData` in 32 — CPU store data; only bits [7:0] are used.
- `ReadData` out 32 — combinational read data.
- `RXD` in 1 — asynchronous serial input.
- `TXD` out 1 — serial output; idles high.

## Operation
- **Register write:** `CE_UART & UART_WR` sampled at a clock edge with TX_FULL=0 loads `WriteData[7:0]` into the TX holding register and sets TX_FULL. If TX_FULL=1 the write is dropped silently.
- **ReadData (combinational):**
  - `CE_UART & ~UART_WR` → {24'b0, rx_data}.
  - `CE_SR` → {27'b0, FRAME_ERR, OVERRUN, RX_VALID, TX_FULL, TX_BUSY} (bits 4..0).
  - Otherwise 0.
- **Read side effects:**
  - An edge with `CE_UART & UART_RD` clears RX_VALID.
  - An edge with `CE_SR` clears OVERRUN and FRAME_ERR.
  - The decoder also raises `UART_RD` with `CE_SR`, so clearing RX_VALID requires `CE_UART`.
- **TX FSM (TX_IDLE, TX_START, TX_DATA, TX_STOP):**
  - In TX_IDLE with TX_FULL=1: move the holding register into the shifter, clear TX_FULL, go to TX_START.
  - Start bit 0, then 8 data bits LSB first, then stop bit 1. Each bit lasts `CLKS_PER_BIT` cycles.
  - At the end of TX_STOP: if TX_FULL=1, go directly to TX_START with the new byte (no idle cycle); otherwise go to TX_IDLE.
  - TX_BUSY = (state ≠ TX_IDLE).
- **RX FSM (RX_IDLE, RX_START, RX_DATA, RX_STOP):**
  - `RXD` passes through a 2-flop synchronizer.
  - RX_IDLE: a synchronized low starts RX_START.
  - RX_START: wait `CLKS_PER_BIT/2` cycles, then re-sample. If the line is high it was a false start; return to RX_IDLE.
  - RX_DATA: sample every `CLKS_PER_BIT` cycles at bit centres, LSB first, 8 bits.
  - RX_STOP: sample the stop bit.
    - Stop=1 and RX_VALID=0: store the byte and set RX_VALID.
    - Stop=1 and RX_VALID=1: discard the byte and set OVERRUN; the old byte is kept.
    - Stop=0: discard the byte and set FRAME_ERR.
  - Return to RX_IDLE.
- **Simultaneous RX:** a data read and a byte completion on the same edge loads the new byte, keeps RX_VALID=1 and does not set OVERRUN.
- **Simultaneous status:** a status read and a flag set on the same edge leaves the flag set (set wins).

## Timing
- **Reset values:** TXD=1; TX_FULL, TX_BUSY, RX_VALID, OVERRUN and FRAME_ERR all 0; both FSMs idle; baud counters 0.
- **ReadData:** 0 while no chip enable is asserted; zero-cycle latency.
- **TX latency:**
  - A write sampled at edge E0 sets TX_FULL after E0.
  - At E1 the FSM enters TX_START and TXD=0.
  - A frame is exactly 10·`CLKS_PER_BIT` cycles.
- **RX_VALID:** rises on the edge that samples the stop bit, about 9.5·`CLKS_PER_BIT` + 2 cycles after the RXD falling edge.
- **Baud counter:** width is $clog2(`CLKS_PER_BIT`). It counts 0..`CLKS_PER_BIT`-1 and wraps, and reloads on every state change.
- **Reset mid-frame:** TXD=1 from the next edge; a partially received byte is discarded.

## Configuration
- **`UART_RX_EN` defined:** full receiver as described.
- **`UART_RX_EN` undefined:**
  - RXD is ignored and no receive logic is instantiated.
  - RX_VALID, OVERRUN and FRAME_ERR are tied 0.
  - A data-register read returns 0.
  - The TX behaviour is identical in both builds.

## Structure
- **Package `uart_pkg`:**
  - TX and RX state enums.
  - Status bit indices (SR_TX_BUSY=0, SR_TX_FULL=1, SR_RX_VALID=2, SR_OVERRUN=3, SR_FRAME_ERR=4).
  - Register offsets 0x500 and 0x504.
- **Sub-module `uart_rx`:**
  - Contains the synchronizer, RX FSM and baud counter.
  - Produces a one-cycle `rx_done` pulse with `rx_byte` and `rx_ferr`.
  - Instantiated only under `UART_RX_EN`.
- **Top level:** holds the TX path, status flags and read mux.

## Test plan
- Reset with `CLKS_PER_BIT`=8 → TXD=1; a status read returns 0x0.
- Write 0xA5 to 0x500 → TX_FULL=1 for one cycle. TXD then shows 0,1,0,1,0,0,1,0,1,1 with each bit 8 cycles long. TX_BUSY=1 for 80 cycles.
- Two back-to-back writes 0x11, 0x22, then a third write while TX_FULL=1 → both frames go out contiguously with no idle gap; the third byte never appears.
- Drive RXD with a 0x3C frame → RX_VALID=1. A read at 0x500 returns 0x3C and RX_VALID clears on the next edge.
- Two frames 0x01, 0x02 with no read in between → data reads 0x01 and OVERRUN=1. A status read returns 0x0C then 0x04.
- Frame with stop bit 0 → FRAME_ERR=1 and RX_VALID=0. A 1-cycle low glitch on RXD is ignored by false-start rejection.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for uart_mmio: FSM state enums, status register bit positions
// and the decoder offsets of the data and status registers.
package uart_pkg;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  localparam int unsigned SR_TX_BUSY   = 0;
  localparam int unsigned SR_TX_FULL   = 1;
  localparam int unsigned SR_RX_VALID  = 2;
  localparam int unsigned SR_OVERRUN   = 3;
  localparam int unsigned SR_FRAME_ERR = 4;
  localparam int unsigned SR_WIDTH     = 5;

  localparam logic [31:0] UART_DATA_OFFSET   = 32'h0000_0500;
  localparam logic [31:0] UART_STATUS_OFFSET = 32'h0000_0504;

endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver for uart_mmio: 2-flop synchronizer, start-bit qualification at half a bit,
// centre sampling; reports each frame with a single-cycle rx_done pulse. Built only with UART_RX_EN.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic       rx_done,
  output logic [7:0] rx_byte,
  output logic       rx_ferr
);

  localparam int unsigned    CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_e     state_q, state_d;
  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          bit_tick;
  logic          half_tick;

  assign bit_tick  = (cnt_q == CNT_LAST);
  assign half_tick = (cnt_q == CNT_HALF);
  assign rx_byte   = shift_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RX_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RX_IDLE:  if (!sync2_q) state_d = RX_START;
      RX_START: if (half_tick) state_d = sync2_q ? RX_IDLE : RX_DATA;
      RX_DATA:  if (bit_tick && bit_q == 3'd7) state_d = RX_STOP;
      RX_STOP:  if (bit_tick) state_d = RX_IDLE;
      default:  state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_done = 1'b0;
    rx_ferr = 1'b0;
    if (state_q == RX_STOP && bit_tick) begin
      rx_done = 1'b1;
      rx_ferr = ~sync2_q;
    end
  end

  always_comb begin
    sync1_d = rxd;
    sync2_d = sync1_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    if (state_q != RX_DATA) begin
      bit_d = '0;
    end else if (bit_tick) begin
      shift_d = {sync2_q, shift_q[7:1]};
      bit_d   = bit_q + 3'd1;
    end
    // Counter restarts on every state change so START counts the half bit from the detected edge.
    if (state_d != state_q || bit_tick || state_q == RX_IDLE) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART: TX holding register + shifter, status flags and read mux.
// Define UART_RX_EN to build the receiver; without it RX flags and data reads are 0.
module uart_mmio
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        CE_UART,
  input  logic        CE_SR,
  input  logic        UART_WR,
  input  logic        UART_RD,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  input  logic        RXD,
  output logic        TXD
);

  localparam int unsigned   CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  tx_state_e     tx_state_q, tx_state_d;
  logic          tx_full_q, tx_full_d;
  logic [7:0]    tx_hold_q, tx_hold_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic          tx_tick;
  logic          tx_load;
  logic          wr_accept;
  logic          tx_busy;

  logic          rx_valid;
  logic          overrun;
  logic          frame_err;
  logic [7:0]    rx_data;
  logic [SR_WIDTH-1:0] status;

  assign tx_tick   = (tx_cnt_q == CNT_LAST);
  assign wr_accept = CE_UART & UART_WR & ~tx_full_q;
  // Holding register is taken either from idle or straight at the end of a stop bit.
  assign tx_load   = tx_full_q & ((tx_state_q == TX_IDLE) | ((tx_state_q == TX_STOP) & tx_tick));

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      tx_state_q <= TX_IDLE;
    end else begin
      tx_state_q <= tx_state_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    unique case (tx_state_q)
      TX_IDLE:  if (tx_full_q) tx_state_d = TX_START;
      TX_START: if (tx_tick) tx_state_d = TX_DATA;
      TX_DATA:  if (tx_tick && tx_bit_q == 3'd7) tx_state_d = TX_STOP;
      TX_STOP:  if (tx_tick) tx_state_d = tx_full_q ? TX_START : TX_IDLE;
      default:  tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    TXD     = 1'b1;
    tx_busy = (tx_state_q != TX_IDLE);
    unique case (tx_state_q)
      TX_START: TXD = 1'b0;
      TX_DATA:  TXD = tx_shift_q[0];
      default:  TXD = 1'b1;
    endcase
  end

  always_comb begin
    tx_full_d  = tx_full_q;
    tx_hold_d  = tx_hold_q;
    tx_shift_d = tx_shift_q;
    tx_bit_d   = tx_bit_q;
    if (wr_accept) begin
      tx_full_d = 1'b1;
      tx_hold_d = WriteData[7:0];
    end else if (tx_load) begin
      tx_full_d = 1'b0;
    end
    if (tx_load) begin
      tx_shift_d = tx_hold_q;
      tx_bit_d   = '0;
    end else if (tx_state_q == TX_DATA && tx_tick) begin
      tx_shift_d = {1'b0, tx_shift_q[7:1]};
      tx_bit_d   = tx_bit_q + 3'd1;
    end
    if (tx_state_d != tx_state_q || tx_tick || tx_state_q == TX_IDLE) begin
      tx_cnt_d = '0;
    end else begin
      tx_cnt_d = tx_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      tx_full_q  <= 1'b0;
      tx_hold_q  <= '0;
      tx_shift_q <= '0;
      tx_bit_q   <= '0;
      tx_cnt_q   <= '0;
    end else begin
      tx_full_q  <= tx_full_d;
      tx_hold_q  <= tx_hold_d;
      tx_shift_q <= tx_shift_d;
      tx_bit_q   <= tx_bit_d;
      tx_cnt_q   <= tx_cnt_d;
    end
  end

`ifdef UART_RX_EN
  logic       rx_done;
  logic [7:0] rx_byte;
  logic       rx_ferr;
  logic       data_rd;
  logic       rx_valid_q, rx_valid_d;
  logic       overrun_q, overrun_d;
  logic       frame_err_q, frame_err_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       unused_in;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk    (CLK),
    .rst_n  (RESET_N),
    .rxd    (RXD),
    .rx_done(rx_done),
    .rx_byte(rx_byte),
    .rx_ferr(rx_ferr)
  );

  assign data_rd   = CE_UART & UART_RD;
  assign unused_in = ^WriteData[31:8];

  always_comb begin
    rx_valid_d  = rx_valid_q;
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    rx_data_d   = rx_data_q;
    if (data_rd) rx_valid_d = 1'b0;
    if (CE_SR) begin
      overrun_d   = 1'b0;
      frame_err_d = 1'b0;
    end
    // Flag sets follow the clears so a set on the read edge wins; a data read frees the register.
    if (rx_done) begin
      if (rx_ferr) begin
        frame_err_d = 1'b1;
      end else if (!rx_valid_q || data_rd) begin
        rx_data_d  = rx_byte;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      rx_data_q   <= '0;
    end else begin
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      rx_data_q   <= rx_data_d;
    end
  end

  assign rx_valid  = rx_valid_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;
  assign rx_data   = rx_data_q;
`else
  logic unused_in;

  assign unused_in = ^{WriteData[31:8], UART_RD, RXD};
  assign rx_valid  = 1'b0;
  assign overrun   = 1'b0;
  assign frame_err = 1'b0;
  assign rx_data   = '0;
`endif

  always_comb begin
    status               = '0;
    status[SR_TX_BUSY]   = tx_busy;
    status[SR_TX_FULL]   = tx_full_q;
    status[SR_RX_VALID]  = rx_valid;
    status[SR_OVERRUN]   = overrun;
    status[SR_FRAME_ERR] = frame_err;
    ReadData             = '0;
    if (CE_UART && !UART_WR) begin
      ReadData = {24'b0, rx_data};
    end else if (CE_SR) begin
      ReadData = {27'b0, status};
    end
  end

endmodule
